jamma_joy_scheduler: RTL and testbench

Time-multiplexes the shared JAMMA joystick bus between player 1 and player 2 and returns two clean, debounced, active-low joystick vectors plus debounced coin inputs. The block drives the splitter select line JSELECT and waits a settle window before each sample. It synchronises and debounces every bit, then publishes per-player registers. It sits between the board pins (JJOY, JCOIN, the local DB9 JOYSTICK) and the arcade core's I_JOYSTICK_A/B, I_PLAYER and I_COIN inputs.

---
 rtl/jamma_joy_pkg.sv | 20 ++
 rtl/jamma_joy_debounce.sv | 38 +++
 rtl/jamma_joy_scheduler.sv | 116 +++++++++++
 tb/tb_jamma_joy_scheduler.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/jamma_joy_pkg.sv
// Shared scan-state type and idle-level constants for the JAMMA joystick scheduler.
package jamma_joy_pkg;

    typedef enum logic [1:0] {
        P1_SETTLE,
        P1_SAMPLE,
        P2_SETTLE,
        P2_SAMPLE
    } scan_state_e;

    localparam logic [7:0] JOY_RELEASED  = 8'hFF;
    localparam logic [1:0] COIN_RELEASED = 2'b11;
    localparam logic       SEL_P1        = 1'b0;
    localparam logic       SEL_P2        = 1'b1;

    function automatic logic is_p2(input scan_state_e s);
        return (s == P2_SETTLE) || (s == P2_SAMPLE);
    endfunction

endpackage

// File: rtl/jamma_joy_debounce.sv
// Per-bit scan debouncer: a bit follows its sample only after DEBOUNCE_SAMPLES
// consecutive disagreeing strobes. Outputs idle high (released).
module jamma_joy_debounce #(
    parameter int WIDTH            = 8,
    parameter int DEBOUNCE_SAMPLES = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             strobe,
    input  logic [WIDTH-1:0] sample,
    output logic [WIDTH-1:0] q
);

    localparam int             CW   = $clog2(DEBOUNCE_SAMPLES + 1);
    localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_SAMPLES - 1);

    logic [CW-1:0] cnt [WIDTH];

    // NOTE: these counters are ordinary flops rather than a RAM, so resetting the whole array is legitimate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '1;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else if (strobe) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sample[i] == q[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == LAST) begin
                    q[i]   <= sample[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/jamma_joy_scheduler.sv
// Time-multiplexes the shared JAMMA joystick bus between P1 and P2 and debounces joysticks and coins.
// Define JAMMA_JOY_LOCAL_MERGE_EN to wire-OR the local DB9 joystick presses into the P1 sample.
module jamma_joy_scheduler #(
    parameter int SETTLE_CYCLES    = 4,
    parameter int DEBOUNCE_SAMPLES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scan_en,
    input  logic [7:0] jjoy,
    input  logic [1:0] jcoin,
    input  logic [5:0] joystick_local,
    output logic       jselect,
    output logic [7:0] joy1,
    output logic [7:0] joy2,
    output logic [1:0] coin,
    output logic       scan_tick
);
    import jamma_joy_pkg::*;

    if (SETTLE_CYCLES < 3) begin : g_bad_settle
        $error("SETTLE_CYCLES must be at least 3");
    end
    if (DEBOUNCE_SAMPLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_SAMPLES must be at least 1");
    end

    localparam int            SW         = $clog2(SETTLE_CYCLES);
    localparam logic [SW-1:0] SETTLE_END = SW'(SETTLE_CYCLES - 1);

    logic [7:0]    jjoy_m, jjoy_s;
    logic [1:0]    jcoin_m, jcoin_s;
    scan_state_e   state_q, state_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic          p1_stb, p2_stb;
    logic [7:0]    p1_sample;

    // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            jjoy_m  <= JOY_RELEASED;
            jjoy_s  <= JOY_RELEASED;
            jcoin_m <= COIN_RELEASED;
            jcoin_s <= COIN_RELEASED;
        end else begin
            jjoy_m  <= jjoy;
            jjoy_s  <= jjoy_m;
            jcoin_m <= jcoin;
            jcoin_s <= jcoin_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= P1_SETTLE;
            cnt_q     <= '0;
            jselect   <= SEL_P1;
            scan_tick <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            jselect   <= is_p2(state_d) ? SEL_P2 : SEL_P1;
            scan_tick <= p2_stb;
        end
    end

    // SAMPLE states always commit and advance, so a sample in flight is never lost to scan_en.
    // NOTE: every output of this block gets a default first, which rules out inferred latches.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p1_stb  = 1'b0;
        p2_stb  = 1'b0;
        unique case (state_q)
            P1_SETTLE, P2_SETTLE: begin
                if (scan_en) begin
                    if (cnt_q == SETTLE_END) begin
                        cnt_d   = '0;
                        state_d = (state_q == P1_SETTLE) ? P1_SAMPLE : P2_SAMPLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            P1_SAMPLE: begin
                p1_stb  = 1'b1;
                state_d = P2_SETTLE;
            end
            P2_SAMPLE: begin
                p2_stb  = 1'b1;
                state_d = P1_SETTLE;
            end
        endcase
    end

`ifdef JAMMA_JOY_LOCAL_MERGE_EN
    assign p1_sample = jjoy_s & {2'b11, joystick_local};
`else
    logic unused_local;
    assign unused_local = ^joystick_local;
    assign p1_sample    = jjoy_s;
`endif

    jamma_joy_debounce #(.WIDTH(8), .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)) u_deb_p1 (
        .clk(clk), .rst_n(rst_n), .strobe(p1_stb), .sample(p1_sample), .q(joy1)
    );

    jamma_joy_debounce #(.WIDTH(8), .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)) u_deb_p2 (
        .clk(clk), .rst_n(rst_n), .strobe(p2_stb), .sample(jjoy_s), .q(joy2)
    );

    jamma_joy_debounce #(.WIDTH(2), .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)) u_deb_coin (
        .clk(clk), .rst_n(rst_n), .strobe(p2_stb), .sample(jcoin_s), .q(coin)
    );

endmodule

// File: tb/tb_jamma_joy_scheduler.sv
// Scoreboard bench for jamma_joy_scheduler: a scan-position reference model feeds a queue that a tick monitor drains.
module tb_jamma_joy_scheduler;

    localparam int S   = 4;
    localparam int DEB = 3;
    localparam int PER = 2 * (S + 1);

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scan_en;
    logic [7:0] p1_val, p2_val;
    logic [7:0] jjoy;
    logic [1:0] jcoin;
    logic [5:0] joystick_local;
    logic       jselect;
    logic [7:0] joy1, joy2;
    logic [1:0] coin;
    logic       scan_tick;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // The splitter answers the select line instantly.
    assign jjoy = jselect ? p2_val : p1_val;

    jamma_joy_scheduler #(.SETTLE_CYCLES(S), .DEBOUNCE_SAMPLES(DEB)) dut (
        .clk(clk), .rst_n(rst_n), .scan_en(scan_en), .jjoy(jjoy), .jcoin(jcoin),
        .joystick_local(joystick_local), .jselect(jselect), .joy1(joy1), .joy2(joy2),
        .coin(coin), .scan_tick(scan_tick)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: position within the scan period, two-deep input history, per-bit run counts.
    int         ph;
    logic [7:0] s1, s2;
    logic [1:0] c1, c2;
    logic [7:0] m_out [3];
    int         m_cnt [3][8];
    logic       m_jsel, m_tick;
    logic [17:0] sb [$];

    task automatic deb(input int ch, input logic [7:0] smp, input int w);
        for (int i = 0; i < w; i++) begin
            if (smp[i] == m_out[ch][i]) begin
                m_cnt[ch][i] = 0;
            end else begin
                m_cnt[ch][i] = m_cnt[ch][i] + 1;
                if (m_cnt[ch][i] == DEB) begin
                    m_out[ch][i] = smp[i];
                    m_cnt[ch][i] = 0;
                end
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin : model
        logic [7:0] bus;
        logic [7:0] p1s;
        if (!rst_n) begin
            ph = 0; s1 = '1; s2 = '1; c1 = '1; c2 = '1;
            for (int c = 0; c < 3; c++) begin
                m_out[c] = '1;
                for (int i = 0; i < 8; i++) m_cnt[c][i] = 0;
            end
            m_jsel = 1'b0;
            m_tick = 1'b0;
            sb.delete();
        end else begin
            bus    = m_jsel ? p2_val : p1_val;
            m_tick = 1'b0;
            if (ph == S) begin
`ifdef JAMMA_JOY_LOCAL_MERGE_EN
                p1s = s2 & {2'b11, joystick_local};
`else
                p1s = s2;
`endif
                deb(0, p1s, 8);
            end
            if (ph == 2 * S + 1) begin
                deb(1, s2, 8);
                deb(2, {6'h3F, c2}, 2);
                m_tick = 1'b1;
                sb.push_back({m_out[0], m_out[1], m_out[2][1:0]});
            end
            if (ph == S || ph == 2 * S + 1 || scan_en) ph = (ph + 1) % PER;
            m_jsel = (ph > S);
            s2 = s1; s1 = bus;
            c2 = c1; c1 = jcoin;
        end
    end

    always @(negedge clk) begin
        check("jselect", jselect, m_jsel);
        check("scan_tick", scan_tick, m_tick);
        check("joy1", joy1, m_out[0]);
        check("joy2", joy2, m_out[1]);
        check("coin", coin, m_out[2][1:0]);
    end

    // Scan monitor: every committed scan must match the next scoreboard entry.
    always @(negedge clk) begin : monitor
        logic [17:0] e;
        if (rst_n === 1'b1 && scan_tick === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_underflow: scan_tick with no expected scan queued (t=%0t)", $time);
            end else begin
                e = sb.pop_front();
                check("sb_joy1", joy1, e[17:10]);
                check("sb_joy2", joy2, e[9:2]);
                check("sb_coin", coin, e[1:0]);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_ph(input int target);
        int n;
        n = 0;
        while (ph != target && n < 100) begin
            step(1);
            n++;
        end
        check("wait_ph_bound", n < 100, 1'b1);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; scan_en = 1'b1;
        p1_val = 8'hFF; p2_val = 8'hFF; jcoin = 2'b11; joystick_local = 6'h3F;
        @(negedge clk);
        check("rst_jselect", jselect, 1'b0);
        check("rst_joy1", joy1, 8'hFF);
        check("rst_joy2", joy2, 8'hFF);
        check("rst_coin", coin, 2'b11);
        check("rst_tick", scan_tick, 1'b0);
        step(2);
        rst_n = 1'b1;

        n = 0;
        do begin @(posedge clk); @(negedge clk); n++; end while (!jselect && n < 50);
        check("jselect_first_rise", n, S + 1);
        n = 0;
        while (!scan_tick && n < 40) begin @(posedge clk); @(negedge clk); n++; end
        n = 0;
        do begin @(posedge clk); @(negedge clk); n++; end while (!scan_tick && n < 40);
        check("tick_period", n, PER);

        // P1 pressing bit 0 only while selected.
        step(1);
        p1_val = 8'hFE;
        step(45);
        check("p1_press_joy1", joy1, 8'hFE);
        check("p1_press_joy2", joy2, 8'hFF);

        // Bit 0 bouncing on every P1 scan never commits.
        p1_val = 8'hFF;
        step(45);
        for (int k = 0; k < 8; k++) begin
            wait_ph(S + 1);
            p1_val[0] = ~p1_val[0];
            step(1);
        end
        check("bounce_joy1", joy1, 8'hFF);

        // Local DB9 joystick.
        p1_val = 8'hFF;
        joystick_local = 6'b111101;
        step(45);
`ifdef JAMMA_JOY_LOCAL_MERGE_EN
        check("local_joy1", joy1, 8'hFD);
`else
        check("local_joy1", joy1, 8'hFF);
`endif
        joystick_local = 6'h3F;
        step(45);

        // Freeze at P2_SETTLE count 2.
        wait_ph(S + 3);
        scan_en = 1'b0;
        step(20);
        check("freeze_jselect", jselect, 1'b1);
        scan_en = 1'b1;
        n = 0;
        do begin @(posedge clk); @(negedge clk); n++; end while (!scan_tick && n < 40);
        check("resume_tick_edges", n, 3);

        // Randomised traffic.
        step(1);
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(7) == 0) p1_val = ($urandom_range(1) == 0) ? 8'hFE : 8'($urandom);
            if ($urandom_range(7) == 0) p2_val = ($urandom_range(1) == 0) ? 8'h7F : 8'($urandom);
            if ($urandom_range(9) == 0) jcoin = 2'($urandom);
            if ($urandom_range(15) == 0) joystick_local = 6'($urandom);
            scan_en = ($urandom_range(9) != 0);
            step(1);
        end

        // Mid-scan reset with settled P2 and coin inputs.
        scan_en = 1'b1; p1_val = 8'hFF; p2_val = 8'h7F; jcoin = 2'b10; joystick_local = 6'h3F;
        step(50);
        check("pre_rst_joy2", joy2, 8'h7F);
        check("pre_rst_coin", coin, 2'b10);
        wait_ph(1);
        rst_n = 1'b0;
        #1;
        check("async_rst_joy2", joy2, 8'hFF);
        check("async_rst_coin", coin, 2'b11);
        check("async_rst_jselect", jselect, 1'b0);
        step(1);
        rst_n = 1'b1;
        n = 0;
        do begin @(posedge clk); @(negedge clk); n++; end while (!jselect && n < 50);
        check("restart_jselect_rise", n, S + 1);
        step(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
